// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Packs decoded RV32I fields into instruction words, range-checks
//               immediates and expands LI into LUI/ADDI sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err
);

    localparam logic [2:0] c_FMT_R  = 3'd0;
    localparam logic [2:0] c_FMT_I  = 3'd1;
    localparam logic [2:0] c_FMT_S  = 3'd2;
    localparam logic [2:0] c_FMT_B  = 3'd3;
    localparam logic [2:0] c_FMT_U  = 3'd4;
    localparam logic [2:0] c_FMT_J  = 3'd5;
    localparam logic [2:0] c_FMT_LI = 3'd6;

    localparam logic [6:0] c_OP_OPIMM = 7'h13;
    localparam logic [6:0] c_OP_LUI   = 7'h37;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_EMIT2 = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_out_inst;
    logic        r_out_last;
    logic        r_out_valid;
    logic        r_err;
    logic [31:0] r_pend_inst;

    logic        w_accept;
    logic        w_is_shift;
    logic        w_fit12;
    logic        w_fit13;
    logic        w_fit21;
    logic [19:0] w_li_hi;
    logic [31:0] w_word;
    logic [31:0] w_second;
    logic        w_two;
    logic        w_bad;

    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // A value fits N signed bits when all bits above N-1 replicate bit N-1.
    assign w_fit12    = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_fit13    = (in_imm[31:12] == {20{in_imm[12]}});
    assign w_fit21    = (in_imm[31:20] == {12{in_imm[20]}});
    assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // (imm + 0x800) >> 12: the carry out of the low 12 bits is exactly imm[11].
    assign w_li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        w_word   = 32'd0;
        w_second = 32'd0;
        w_two    = 1'b0;
        w_bad    = 1'b0;
        case (in_fmt)
            c_FMT_R: begin
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            c_FMT_I: begin
                if (w_is_shift) begin
                    w_bad  = |in_imm[31:5];
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    w_bad  = !w_fit12;
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                end
            end
            c_FMT_S: begin
                w_bad  = !w_fit12;
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            c_FMT_B: begin
                w_bad  = !w_fit13 || in_imm[0];
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            end
            c_FMT_U: begin
                w_bad  = |in_imm[11:0];
                w_word = {in_imm[31:12], in_rd, in_opcode};
            end
            c_FMT_J: begin
                w_bad  = !w_fit21 || in_imm[0];
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
            end
            c_FMT_LI: begin
                if (w_fit12) begin
                    w_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, c_OP_OPIMM};
                end else begin
                    // lo shares its low 12 bits with imm, so lo != 0 iff imm[11:0] != 0.
                    w_word   = {w_li_hi, in_rd, c_OP_LUI};
                    w_two    = |in_imm[11:0];
                    w_second = {in_imm[11:0], in_rd, 3'b000, in_rd, c_OP_OPIMM};
                end
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_out_inst  <= 32'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_pend_inst <= 32'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            // Accept implies the output slot is empty or being drained.
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_inst  <= w_word;
                            r_out_last  <= !w_two;
                            r_out_valid <= 1'b1;
                            if (w_two) begin
                                r_pend_inst <= w_second;
                                r_state     <= S_EMIT2;
                            end
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_EMIT2: begin
                    if (!r_out_valid || out_ready) begin
                        r_out_inst  <= r_pend_inst;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Scoreboard bench for inst_encoder using known RV32I encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;
    logic [32:0] exp_q[$];

    inst_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are judged on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_word: got unexpected inst=%h last=%b, required no word", out_inst, out_last);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_inst} !== e)
                    $display("FAIL out_word: got inst=%h last=%b, required inst=%h last=%b",
                             out_inst, out_last, e[31:0], e[32]);
                else
                    n_pass++;
            end
        end
    end

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, output int waits);
        set_fields(fmt, op, f3, f7, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_total += 4;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid); else n_pass++;
        if (out_inst !== 32'd0) $display("FAIL reset_inst: got %h, required 0", out_inst); else n_pass++;
        if (out_last !== 1'b0)  $display("FAIL reset_last: got %b, required 0", out_last); else n_pass++;
        if (err !== 1'b0)       $display("FAIL reset_err: got %b, required 0", err); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", in_ready); else n_pass++;
    endtask

    task automatic test_single;
        int w;
        exp_q.push_back({1'b1, 32'h00500093});
        issue(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, w);
        n_total += 2;
        if (out_valid !== 1'b1) $display("FAIL addi_latency: got out_valid=%b, required 1", out_valid); else n_pass++;
        if ({out_last, out_inst} !== {1'b1, 32'h00500093})
            $display("FAIL addi_word: got inst=%h last=%b, required 00500093 1", out_inst, out_last);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int w;
        int stalls = 0;
        exp_q.push_back({1'b1, 32'h0021A423});
        issue(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd3, 5'd2, 32'd8, w); stalls += w;
        exp_q.push_back({1'b1, 32'hFE208EE3});
        issue(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, w); stalls += w;
        exp_q.push_back({1'b1, 32'h4030D093});
        issue(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3, w); stalls += w;
        exp_q.push_back({1'b1, 32'h002081B3});
        issue(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, w); stalls += w;
        exp_q.push_back({1'b1, 32'h123450B7});
        issue(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h12345000, w); stalls += w;
        exp_q.push_back({1'b1, 32'h008000EF});
        issue(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, w); stalls += w;
        n_total++;
        if (stalls !== 0) $display("FAIL throughput: got %0d stall cycles, required 0", stalls); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_li;
        int w;
        exp_q.push_back({1'b0, 32'h123462B7});
        exp_q.push_back({1'b1, 32'hFFF28293});
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, w);
        n_total += 2;
        if ({out_last, out_inst} !== {1'b0, 32'h123462B7})
            $display("FAIL li_word1: got inst=%h last=%b, required 123462b7 0", out_inst, out_last);
        else n_pass++;
        if (in_ready !== 1'b0) $display("FAIL li_ready_emit2: got %b, required 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_total += 2;
        if ({out_valid, out_last, out_inst} !== {1'b1, 1'b1, 32'hFFF28293})
            $display("FAIL li_word2: got valid=%b inst=%h last=%b, required 1 fff28293 1",
                     out_valid, out_inst, out_last);
        else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL li_ready_after: got %b, required 1", in_ready); else n_pass++;
        exp_q.push_back({1'b1, 32'h000012B7});
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h00001000, w);
        exp_q.push_back({1'b1, 32'hFFF00293});
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, w);
        @(posedge clk); #1;
    endtask

    task automatic test_errors;
        int w;
        logic [2:0]  fmts [3] = '{3'd3, 3'd1, 3'd7};
        logic [31:0] imms [3] = '{32'd3, 32'd2048, 32'd0};
        for (int i = 0; i < 3; i++) begin
            issue(fmts[i], 7'h63, 3'd0, 7'h00, 5'd1, 5'd1, 5'd2, imms[i], w);
            n_total += 2;
            if (err !== 1'b1) $display("FAIL err_pulse%0d: got %b, required 1", i, err); else n_pass++;
            if (out_valid !== 1'b0) $display("FAIL err_novalid%0d: got %b, required 0", i, out_valid); else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (err !== 1'b0) $display("FAIL err_width%0d: got %b, required 0", i, err); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int w;
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h00700113});
        issue(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd7, w);
        exp_q.push_back({1'b1, 32'h0021A423});
        set_fields(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd3, 5'd2, 32'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({in_ready, out_valid, out_inst} !== {1'b0, 1'b1, 32'h00700113})
                $display("FAIL bp_hold%0d: got ready=%b valid=%b inst=%h, required 0 1 00700113",
                         i, in_ready, out_valid, out_inst);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, out_inst} !== {1'b1, 32'h0021A423})
            $display("FAIL bp_no_bubble: got valid=%b inst=%h, required 1 0021a423", out_valid, out_inst);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_emit2;
        int w;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h123462B7});
        exp_q.push_back({1'b1, 32'hFFF28293});
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, w);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_total += 2;
        if ({out_valid, out_inst, out_last} !== {1'b0, 32'd0, 1'b0})
            $display("FAIL rst_async: got valid=%b inst=%h last=%b, required 0 0 0", out_valid, out_inst, out_last);
        else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL rst_idle: got in_ready=%b, required 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL rst_no_word2_%0d: got out_valid=%b, required 0", i, out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        test_reset();
        test_single();
        test_back_to_back();
        test_li();
        test_errors();
        test_backpressure();
        test_reset_emit2();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
